mcpu_core_stage_wb: RTL and testbench
=====================================

Name: mcpu_core_stage_wb

Overview:
Writeback stage for the 4-lane MCPU core. It sits directly upstream of the register file and drives its write ports (wb2rf_*).
- Registers the per-lane result bundle arriving from the MEM stage.
- Merges results from the long-latency unit (divider) into idle writeback lanes. Those results pass through a small ordered queue.
- Squashes stale long-op results that a younger bundle overwrites.

Parameters:
LONGQ_DEPTH, 2, entries in the long-op result queue (power of two, ≥2)
PERF_W, 32, width of each performance counter (optional feature only)

Ports:
clkrst_core_clk  input  1  core clock; all state updates on its rising edge
clkrst_core_rst  input  1  synchronous reset, active-high
mem2wb_valid  input  1  bundle present this cycle
mem2wb_rd_num  input  20  lane i destination at [5i+4:5i]
mem2wb_rd_data  input  128  lane i data at [32i+31:32i]
mem2wb_rd_we  input  4  lane i GPR write enable
mem2wb_pred_we  input  4  lane i predicate write enable
div2wb_valid  input  1  long-op result offered
div2wb_rd_num  input  5  long-op destination GPR
div2wb_rd_data  input  32  long-op result
wb2div_ready  output  1  queue can accept; transfer when valid&ready
wb2rf_rd_num0..3  output  5 each  lane destination to register file
wb2rf_rd_data0..3  output  32 each  lane data to register file
wb2rf_rd_we0..3  output  1 each  GPR write enable to register file
wb2rf_pred_we0..3  output  1 each  predicate write enable to register file

Behaviour:
- Clocking and reset: one clock, clkrst_core_clk. Reset clkrst_core_rst is synchronous and active-high.
- Reset values: all wb2rf_* outputs 0; queue empty; wb2div_ready 0 while reset is high.
- After reset: wb2div_ready = (queue count < LONGQ_DEPTH), decoded from registered count.
- Bundle path: latency is 1 cycle.
  - If mem2wb_valid=1 at edge N, lane i outputs at N+1 equal lane i inputs.
  - If mem2wb_valid=0, all lane enables at N+1 are 0.
  - No backpressure to MEM: every bundle is accepted.
- Lane free: a lane is free when mem2wb_valid=0, or when its rd_we=0 and pred_we=0.
- Long-op insertion: if the queue is non-empty and any lane is free, pop the head into the lowest-numbered free lane.
  - That lane gets rd_we=1, pred_we=0, the head's rd_num and rd_data.
  - It is visible at N+1, together with the bundle.
  - If no lane is free, the head waits; at most one pop per cycle.
- Queue:
  - FIFO order.
  - Push and pop in the same cycle are allowed.
  - A push into an empty queue cannot be popped in the same cycle; minimum div-to-regfile latency is 2 cycles.
  - Full: wb2div_ready=0 and div2wb_valid is ignored.
- Squash: the divider result is always older than any bundle in MEM. If an accepted bundle has lane rd_we=1 with rd_num=R, then in the same cycle:
  - every queued entry with rd_num=R is invalidated and removed without writing;
  - a same-cycle incoming div2wb entry with rd_num=R is accepted (handshake completes) but discarded.
  - A squashed head does not consume a lane, and the next valid entry may pop that cycle.
  - Queue compaction must preserve order.
- Predicate lanes pass through unchanged: wb2rf_rd_num[1:0] selects the predicate and data[0] is the value. They do not participate in squash.
- Reset mid-operation: queued entries are discarded; no writes are emitted on the cycle after reset.

Optional Feature:
MCPU_CORE_WB_PERF_EN
- Defined: adds outputs wb_perf_bundles, wb_perf_longops, wb_perf_squashed, wb_perf_waits, each PERF_W bits.
  - wb_perf_bundles: valid bundles accepted.
  - wb_perf_longops: long-ops written.
  - wb_perf_squashed: entries discarded by squash.
  - wb_perf_waits: cycles with a non-empty queue and no free lane.
  - Counters wrap at 2^PERF_W and clear on reset.
- Undefined: these ports and their counters do not exist; functional behaviour is identical.

Test Plan:
- Reset high for 3 cycles while div2wb_valid=1 -> wb2div_ready=0, all wb2rf_*_we=0, no queue push; after release ready=1.
- Bundle with lane0 rd_num=5, data=0x1234, rd_we=1 and lane2 pred_we=1, data=1 -> next cycle wb2rf_rd_we0=1 (r5=0x1234), wb2rf_pred_we2=1, other enables 0.
- Div result r7=0xDEAD pushed at N; bundle at N+1 uses lanes 0,1 -> at N+2 lane2 has rd_num=7, data=0xDEAD, rd_we=1, pred_we=0.
- All 4 lanes busy for 4 cycles while three div results are offered -> first two accepted, ready=0 on the third; lanes free up -> results emerge in FIFO order one per cycle, ready returns to 1.
- Queue holds r9, r10 (in that order); bundle writes r9 -> r9 entry dropped, r10 written in same cycle's free lane, r9 value never reaches the regfile; with MCPU_CORE_WB_PERF_EN, wb_perf_squashed=1.
- Incoming div r3 accepted in the same cycle a bundle writes r3 -> handshake completes, queue count unchanged, no r3 long-op write ever emitted.

Source files
------------

// File: rtl/mcpu_core_stage_wb.sv
// MCPU writeback stage: registers the 4-lane MEM bundle and merges queued divider results into idle lanes.
// Optional performance counters are enabled by defining MCPU_CORE_WB_PERF_EN.
module mcpu_core_stage_wb #(
    parameter int LONGQ_DEPTH = 2
`ifdef MCPU_CORE_WB_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic         clkrst_core_clk,
    input  logic         clkrst_core_rst,
    input  logic         mem2wb_valid,
    input  logic [19:0]  mem2wb_rd_num,
    input  logic [127:0] mem2wb_rd_data,
    input  logic [3:0]   mem2wb_rd_we,
    input  logic [3:0]   mem2wb_pred_we,
    input  logic         div2wb_valid,
    input  logic [4:0]   div2wb_rd_num,
    input  logic [31:0]  div2wb_rd_data,
    output logic         wb2div_ready,
    output logic [4:0]   wb2rf_rd_num0,
    output logic [4:0]   wb2rf_rd_num1,
    output logic [4:0]   wb2rf_rd_num2,
    output logic [4:0]   wb2rf_rd_num3,
    output logic [31:0]  wb2rf_rd_data0,
    output logic [31:0]  wb2rf_rd_data1,
    output logic [31:0]  wb2rf_rd_data2,
    output logic [31:0]  wb2rf_rd_data3,
    output logic         wb2rf_rd_we0,
    output logic         wb2rf_rd_we1,
    output logic         wb2rf_rd_we2,
    output logic         wb2rf_rd_we3,
    output logic         wb2rf_pred_we0,
    output logic         wb2rf_pred_we1,
    output logic         wb2rf_pred_we2,
    output logic         wb2rf_pred_we3
`ifdef MCPU_CORE_WB_PERF_EN
    , output logic [PERF_W-1:0] wb_perf_bundles
    , output logic [PERF_W-1:0] wb_perf_longops
    , output logic [PERF_W-1:0] wb_perf_squashed
    , output logic [PERF_W-1:0] wb_perf_waits
`endif
);

    localparam int CNT_W = $clog2(LONGQ_DEPTH) + 1;

    logic [CNT_W-1:0]       q_cnt, q_cnt_nxt;
    logic [4:0]             q_num      [LONGQ_DEPTH];
    logic [31:0]            q_data     [LONGQ_DEPTH];
    logic [4:0]             q_num_nxt  [LONGQ_DEPTH];
    logic [31:0]            q_data_nxt [LONGQ_DEPTH];
    logic [LONGQ_DEPTH-1:0] q_hit;
    logic [3:0]             lane_free;
    logic                   any_free;
    logic                   div_hit;
    logic                   push_keep;
    logic                   pop_vld;
    logic                   ins_done;
    logic [4:0]             pop_num;
    logic [31:0]            pop_data;
    int                     keep;

    logic [4:0]  rf_num      [4];
    logic [31:0] rf_data     [4];
    logic [3:0]  rf_we,  rf_pwe;
    logic [4:0]  rf_num_nxt  [4];
    logic [31:0] rf_data_nxt [4];
    logic [3:0]  rf_we_nxt, rf_pwe_nxt;

    assign wb2div_ready = !clkrst_core_rst && (q_cnt < CNT_W'(LONGQ_DEPTH));

    // Only GPR writes squash; predicate lanes never match queued divider entries.
    function automatic logic bundle_hit(input logic [4:0] num);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++)
            hit = hit | (mem2wb_valid & mem2wb_rd_we[i] & (mem2wb_rd_num[5*i +: 5] == num));
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++)
            lane_free[i] = !mem2wb_valid || (!mem2wb_rd_we[i] && !mem2wb_pred_we[i]);
        any_free = |lane_free;
    end

    // Survivors are compacted in order; the first survivor pops if any lane is free.
    always_comb begin
        q_num_nxt  = q_num;
        q_data_nxt = q_data;
        q_hit      = '0;
        pop_vld    = 1'b0;
        pop_num    = '0;
        pop_data   = '0;
        keep       = 0;
        for (int j = 0; j < LONGQ_DEPTH; j++) begin
            q_hit[j] = (j < int'(q_cnt)) && bundle_hit(q_num[j]);
            if ((j < int'(q_cnt)) && !q_hit[j]) begin
                if (!pop_vld && any_free) begin
                    pop_vld  = 1'b1;
                    pop_num  = q_num[j];
                    pop_data = q_data[j];
                end else begin
                    for (int m = 0; m < LONGQ_DEPTH; m++) begin
                        if (m == keep) begin
                            q_num_nxt[m]  = q_num[j];
                            q_data_nxt[m] = q_data[j];
                        end
                    end
                    keep = keep + 1;
                end
            end
        end
        div_hit   = bundle_hit(div2wb_rd_num);
        push_keep = div2wb_valid && wb2div_ready && !div_hit;
        if (push_keep) begin
            for (int m = 0; m < LONGQ_DEPTH; m++) begin
                if (m == keep) begin
                    q_num_nxt[m]  = div2wb_rd_num;
                    q_data_nxt[m] = div2wb_rd_data;
                end
            end
            keep = keep + 1;
        end
        q_cnt_nxt = CNT_W'(keep);
    end

    always_comb begin
        ins_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rf_num_nxt[i]  = mem2wb_rd_num[5*i +: 5];
            rf_data_nxt[i] = mem2wb_rd_data[32*i +: 32];
            rf_we_nxt[i]   = mem2wb_valid & mem2wb_rd_we[i];
            rf_pwe_nxt[i]  = mem2wb_valid & mem2wb_pred_we[i];
            if (pop_vld && lane_free[i] && !ins_done) begin
                rf_num_nxt[i]  = pop_num;
                rf_data_nxt[i] = pop_data;
                rf_we_nxt[i]   = 1'b1;
                rf_pwe_nxt[i]  = 1'b0;
                ins_done       = 1'b1;
            end
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            q_cnt  <= '0;
            rf_we  <= '0;
            rf_pwe <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_num[i]  <= '0;
                rf_data[i] <= '0;
            end
        end else begin
            q_cnt   <= q_cnt_nxt;
            rf_we   <= rf_we_nxt;
            rf_pwe  <= rf_pwe_nxt;
            rf_num  <= rf_num_nxt;
            rf_data <= rf_data_nxt;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        q_num  <= q_num_nxt;
        q_data <= q_data_nxt;
    end

    assign wb2rf_rd_num0  = rf_num[0];
    assign wb2rf_rd_num1  = rf_num[1];
    assign wb2rf_rd_num2  = rf_num[2];
    assign wb2rf_rd_num3  = rf_num[3];
    assign wb2rf_rd_data0 = rf_data[0];
    assign wb2rf_rd_data1 = rf_data[1];
    assign wb2rf_rd_data2 = rf_data[2];
    assign wb2rf_rd_data3 = rf_data[3];
    assign wb2rf_rd_we0   = rf_we[0];
    assign wb2rf_rd_we1   = rf_we[1];
    assign wb2rf_rd_we2   = rf_we[2];
    assign wb2rf_rd_we3   = rf_we[3];
    assign wb2rf_pred_we0 = rf_pwe[0];
    assign wb2rf_pred_we1 = rf_pwe[1];
    assign wb2rf_pred_we2 = rf_pwe[2];
    assign wb2rf_pred_we3 = rf_pwe[3];

`ifdef MCPU_CORE_WB_PERF_EN
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            wb_perf_bundles  <= '0;
            wb_perf_longops  <= '0;
            wb_perf_squashed <= '0;
            wb_perf_waits    <= '0;
        end else begin
            wb_perf_bundles  <= wb_perf_bundles + PERF_W'(mem2wb_valid);
            wb_perf_longops  <= wb_perf_longops + PERF_W'(pop_vld);
            wb_perf_squashed <= wb_perf_squashed + PERF_W'($countones(q_hit))
                                + PERF_W'(div2wb_valid && wb2div_ready && div_hit);
            wb_perf_waits    <= wb_perf_waits + PERF_W'((q_cnt != '0) && !any_free);
        end
    end
`endif

endmodule

// File: tb/tb_mcpu_core_stage_wb.sv
// Scoreboard bench for mcpu_core_stage_wb: stimulus queues expected regfile writes, a monitor checks them.
module tb_mcpu_core_stage_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem2wb_valid;
    logic [19:0]  mem2wb_rd_num;
    logic [127:0] mem2wb_rd_data;
    logic [3:0]   mem2wb_rd_we;
    logic [3:0]   mem2wb_pred_we;
    logic         div2wb_valid;
    logic [4:0]   div2wb_rd_num;
    logic [31:0]  div2wb_rd_data;
    logic         wb2div_ready;
    logic [4:0]   o_num  [4];
    logic [31:0]  o_data [4];
    logic [3:0]   o_we, o_pwe;
`ifdef MCPU_CORE_WB_PERF_EN
    logic [31:0]  perf_bundles, perf_longops, perf_squashed, perf_waits;
`endif

    typedef struct {
        int          lane;
        logic [4:0]  num;
        logic [31:0] data;
        logic        pred;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mcpu_core_stage_wb dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .mem2wb_valid    (mem2wb_valid),
        .mem2wb_rd_num   (mem2wb_rd_num),
        .mem2wb_rd_data  (mem2wb_rd_data),
        .mem2wb_rd_we    (mem2wb_rd_we),
        .mem2wb_pred_we  (mem2wb_pred_we),
        .div2wb_valid    (div2wb_valid),
        .div2wb_rd_num   (div2wb_rd_num),
        .div2wb_rd_data  (div2wb_rd_data),
        .wb2div_ready    (wb2div_ready),
        .wb2rf_rd_num0   (o_num[0]),
        .wb2rf_rd_num1   (o_num[1]),
        .wb2rf_rd_num2   (o_num[2]),
        .wb2rf_rd_num3   (o_num[3]),
        .wb2rf_rd_data0  (o_data[0]),
        .wb2rf_rd_data1  (o_data[1]),
        .wb2rf_rd_data2  (o_data[2]),
        .wb2rf_rd_data3  (o_data[3]),
        .wb2rf_rd_we0    (o_we[0]),
        .wb2rf_rd_we1    (o_we[1]),
        .wb2rf_rd_we2    (o_we[2]),
        .wb2rf_rd_we3    (o_we[3]),
        .wb2rf_pred_we0  (o_pwe[0]),
        .wb2rf_pred_we1  (o_pwe[1]),
        .wb2rf_pred_we2  (o_pwe[2]),
        .wb2rf_pred_we3  (o_pwe[3])
`ifdef MCPU_CORE_WB_PERF_EN
        , .wb_perf_bundles  (perf_bundles)
        , .wb_perf_longops  (perf_longops)
        , .wb_perf_squashed (perf_squashed)
        , .wb_perf_waits    (perf_waits)
`endif
    );

    // Every asserted write enable must match the next expected write, including its cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (o_we[i] || o_pwe[i]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_write unexpected: lane=%0d num=%0d data=%h we=%b pwe=%b cyc=%0d",
                             i, o_num[i], o_data[i], o_we[i], o_pwe[i], cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.lane != i || mon_e.num != o_num[i] || mon_e.data != o_data[i] ||
                        mon_e.pred != o_pwe[i] || mon_e.pred == o_we[i] || mon_e.cyc != cyc) begin
                        errors++;
                        $display("FAIL wb_write got lane=%0d num=%0d data=%h we=%b pwe=%b cyc=%0d, want lane=%0d num=%0d data=%h pred=%0d cyc=%0d",
                                 i, o_num[i], o_data[i], o_we[i], o_pwe[i], cyc,
                                 mon_e.lane, mon_e.num, mon_e.data, mon_e.pred, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic expect_wr(input int ln, input logic [4:0] n, input logic [31:0] d, input logic p, input int at);
        exp_t e;
        e.lane = ln; e.num = n; e.data = d; e.pred = p; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic clr_mem();
        mem2wb_valid   = 1'b0;
        mem2wb_rd_num  = '0;
        mem2wb_rd_data = '0;
        mem2wb_rd_we   = '0;
        mem2wb_pred_we = '0;
    endtask

    task automatic set_div(input logic v, input logic [4:0] n, input logic [31:0] d);
        div2wb_valid   = v;
        div2wb_rd_num  = n;
        div2wb_rd_data = d;
    endtask

    // Drives one bundle lane; pass-through writes appear one cycle later.
    task automatic lane(input int i, input logic [4:0] n, input logic [31:0] d, input logic we, input logic pwe);
        mem2wb_valid               = 1'b1;
        mem2wb_rd_num[5*i +: 5]    = n;
        mem2wb_rd_data[32*i +: 32] = d;
        mem2wb_rd_we[i]            = we;
        mem2wb_pred_we[i]          = pwe;
        if (we || pwe) expect_wr(i, n, d, pwe, cyc + 1);
    endtask

    task automatic busy(input int tag);
        clr_mem();
        for (int i = 0; i < 4; i++) lane(i, 5'(11 + i), 32'(tag * 16 + i), 1'b1, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clr_mem();
        set_div(1'b1, 5'd1, 32'h111);
        repeat (3) begin
            step();
            chk("rst_ready", {31'd0, wb2div_ready}, 32'd0);
            chk("rst_enables", {24'd0, o_we, o_pwe}, 32'd0);
        end
        rst = 1'b0;
        set_div(1'b0, 5'd0, 32'd0);
        #1;
        chk("release_ready", {31'd0, wb2div_ready}, 32'd1);

        // Bundle pass-through with a predicate lane
        clr_mem();
        lane(0, 5'd5, 32'h1234, 1'b1, 1'b0);
        lane(2, 5'd2, 32'h1, 1'b0, 1'b1);
        step();

        // Long-op fills the lowest free lane
        clr_mem();
        set_div(1'b1, 5'd7, 32'hDEAD);
        chk("div7_ready", {31'd0, wb2div_ready}, 32'd1);
        step();
        set_div(1'b0, 5'd0, 32'd0);
        lane(0, 5'd1, 32'h100, 1'b1, 1'b0);
        lane(1, 5'd2, 32'h200, 1'b1, 1'b0);
        expect_wr(2, 5'd7, 32'hDEAD, 1'b0, cyc + 1);
        step();

        // All lanes busy: queue fills, then drains in FIFO order
        busy(1); set_div(1'b1, 5'd20, 32'hA20);
        chk("fill_ready0", {31'd0, wb2div_ready}, 32'd1);
        step();
        busy(2); set_div(1'b1, 5'd21, 32'hA21);
        chk("fill_ready1", {31'd0, wb2div_ready}, 32'd1);
        step();
        busy(3); set_div(1'b1, 5'd22, 32'hA22);
        chk("full_ready2", {31'd0, wb2div_ready}, 32'd0);
        step();
        busy(4);
        chk("full_ready3", {31'd0, wb2div_ready}, 32'd0);
        step();
        clr_mem(); set_div(1'b0, 5'd0, 32'd0);
        chk("full_ready4", {31'd0, wb2div_ready}, 32'd0);
        expect_wr(0, 5'd20, 32'hA20, 1'b0, cyc + 1);
        step();
        chk("drain_ready1", {31'd0, wb2div_ready}, 32'd1);
        expect_wr(0, 5'd21, 32'hA21, 1'b0, cyc + 1);
        step();
        chk("drain_ready0", {31'd0, wb2div_ready}, 32'd1);

        // Queued r9 squashed by bundle write, r10 pops the same cycle
        busy(5); set_div(1'b1, 5'd9, 32'h999);
        step();
        busy(6); set_div(1'b1, 5'd10, 32'hAAA);
        chk("sq_ready", {31'd0, wb2div_ready}, 32'd1);
        step();
        clr_mem(); set_div(1'b0, 5'd0, 32'd0);
        lane(0, 5'd9, 32'h5959, 1'b1, 1'b0);
        expect_wr(1, 5'd10, 32'hAAA, 1'b0, cyc + 1);
        step();
`ifdef MCPU_CORE_WB_PERF_EN
        chk("perf_squashed1", perf_squashed, 32'd1);
        chk("perf_longops4", perf_longops, 32'd4);
`endif

        // Incoming r3 discarded by same-cycle bundle write of r3
        clr_mem();
        lane(0, 5'd3, 32'h3030, 1'b1, 1'b0);
        set_div(1'b1, 5'd3, 32'h333);
        chk("sq_in_ready0", {31'd0, wb2div_ready}, 32'd1);
        step();
        busy(7); set_div(1'b1, 5'd23, 32'h2323);
        step();
        busy(8); set_div(1'b1, 5'd24, 32'h2424);
        chk("sq_in_ready1", {31'd0, wb2div_ready}, 32'd1);
        step();
        clr_mem(); set_div(1'b0, 5'd0, 32'd0);
        chk("sq_in_full", {31'd0, wb2div_ready}, 32'd0);
        expect_wr(0, 5'd23, 32'h2323, 1'b0, cyc + 1);
        step();
        expect_wr(0, 5'd24, 32'h2424, 1'b0, cyc + 1);
        step();
`ifdef MCPU_CORE_WB_PERF_EN
        chk("perf_squashed2", perf_squashed, 32'd2);
`endif

        // Enables ignored when the bundle is not valid
        clr_mem();
        mem2wb_rd_we   = 4'hF;
        mem2wb_pred_we = 4'hF;
        mem2wb_rd_num  = 20'hFFFFF;
        step();

        // Reset with a loaded queue discards its entries
        busy(9); set_div(1'b1, 5'd25, 32'h2525);
        step();
        busy(10); set_div(1'b1, 5'd26, 32'h2626);
        step();
        clr_mem(); set_div(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        chk("midrst_enables", {24'd0, o_we, o_pwe}, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, wb2div_ready}, 32'd1);
`ifdef MCPU_CORE_WB_PERF_EN
        chk("perf_rst_squashed", perf_squashed, 32'd0);
`endif
        repeat (4) step();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
